// File: rtl/mux_lanes_n_to_1.sv
// Parametrised N:1 lane serialiser. Captures a frame of NUM_LANES lanes (data + valid) and
// emits one lane per clk_4f cycle, tagged with its source lane. A frame closes when at most
// one lane is still pending, which also raises sample_req so the next capture lands on the
// same edge as the frame's last emission, leaving no bubble between frames.
module mux_lanes_n_to_1 #(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SKIP_INVALID = 0
) (
  input  logic                            clk_4f,
  input  logic                            reset,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_LANES-1:0]            valid_in,
  output logic                            sample_req,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            valid_out,
  output logic [$clog2(NUM_LANES)-1:0]    lane_id,
  output logic                            frame_start
);

  localparam int unsigned LW = $clog2(NUM_LANES);
  localparam logic [NUM_LANES-1:0] OneLane = NUM_LANES'(1);

  typedef enum logic [1:0] {StStart, StArm, StRun} state_e;

  state_e                          state_q, state_d;
  logic [NUM_LANES*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_LANES-1:0]            vshadow_q, vshadow_d;
  // Lanes of the current frame not yet emitted; lowest set bit is the next lane.
  logic [NUM_LANES-1:0]            pend_q, pend_d;
  // Emissions so far in the current frame; zero marks the frame's first output cycle.
  logic [LW-1:0]                   phase_q, phase_d;
  logic                            sample_req_q, sample_req_d;
  logic [DATA_WIDTH-1:0]           data_out_q, data_out_d;
  logic                            valid_out_q, valid_out_d;
  logic [LW-1:0]                   lane_id_q, lane_id_d;
  logic                            frame_start_q, frame_start_d;

  logic [DATA_WIDTH-1:0]           lanes [NUM_LANES];
  logic [LW-1:0]                   lane_ptr;
  logic                            capture;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lanes[g] = shadow_q[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lane pointer: index of the lowest pending lane (0 when nothing is pending).
  always_comb begin
    lane_ptr = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pend_q[i]) lane_ptr = LW'(i);
    end
  end

  // Next-state: FSM sequencing, lane emission, capture and sample_req lookahead.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    vshadow_d     = vshadow_q;
    pend_d        = pend_q;
    phase_d       = phase_q;
    sample_req_d  = 1'b0;
    data_out_d    = '0;
    valid_out_d   = 1'b0;
    lane_id_d     = '0;
    frame_start_d = 1'b0;
    capture       = 1'b0;

    unique case (state_q)
      StStart: begin
        sample_req_d = 1'b1;
        state_d      = StArm;
      end
      StArm: begin
        capture = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        // An empty pending set only occurs for an all-invalid compacted frame: idle slot.
        valid_out_d   = (pend_q != '0) && vshadow_q[lane_ptr];
        data_out_d    = valid_out_d ? lanes[lane_ptr] : '0;
        lane_id_d     = lane_ptr;
        frame_start_d = (phase_q == '0);
        pend_d        = pend_q & (pend_q - OneLane);
        phase_d       = phase_q + LW'(1);
        capture       = sample_req_q;
      end
      default: state_d = StStart;
    endcase

    if (capture) begin
      shadow_d  = data_in;
      vshadow_d = valid_in;
      pend_d    = (SKIP_INVALID != 0) ? valid_in : '1;
      phase_d   = '0;
    end

    // The next edge ends the frame once at most one lane is left to emit.
    if (state_d == StRun) begin
      sample_req_d = ((pend_d & (pend_d - OneLane)) == '0);
    end
  end

  // State and output registers; reset discards any frame in flight.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q       <= StStart;
      shadow_q      <= '0;
      vshadow_q     <= '0;
      pend_q        <= '0;
      phase_q       <= '0;
      sample_req_q  <= 1'b0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      lane_id_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      vshadow_q     <= vshadow_d;
      pend_q        <= pend_d;
      phase_q       <= phase_d;
      sample_req_q  <= sample_req_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      lane_id_q     <= lane_id_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sample_req  = sample_req_q;
  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign lane_id     = lane_id_q;
  assign frame_start = frame_start_q;

endmodule
